imem_fetch_responder: RTL and testbench
=======================================

# imem_fetch_responder

Instruction-side responder for the dual-issue fetch stage. Accepts the 10-bit F2 fetch address, returns a 64-bit fetch packet holding two consecutive instructions, and asserts `f2_stall_o` until that packet is valid. It sits between the pipeline's F2 port and a 32-bit single-word backing instruction memory, filling packets through a req/ack handshake.

## Interface
Parameters:
- `MEM_AW`, 8: backing-memory word-address width; the byte-address span is `MEM_AW+2` = 10 bits.

Ports (one clock; reset is synchronous and active-high):
- `clock_i` in 1: clock, rising edge.
- `reset_i` in 1: synchronous active-high reset.
- `iaddr_i` in 10: F2 fetch byte address; bits [1:0] are ignored.
- `idata_o` out 64: fetch packet; [63:32] = word at `iaddr_i`, [31:0] = word at `iaddr_i+4`.
- `f2_stall_o` out 1: high while the requested packet is not resident.
- `mem_req_o` out 1: backing-memory read request.
- `mem_addr_o` out MEM_AW: backing word address.
- `mem_ack_i` in 1: request accepted; `mem_rdata_i` valid this cycle.
- `mem_rdata_i` in 32: read data.

## Operation
- Packet buffer A: `valid`, `tag` = word address of slot 0 (MEM_AW bits), `hi`/`lo` 32-bit words.
- Hit: `valid && tag == iaddr_i[9:2]`. `f2_stall_o = !hit` (combinational). `idata_o = {hi, lo}` at all times, meaningful only when the stall is low.
- FSM states:
  - IDLE: if `!hit`, latch `fill_tag <= iaddr_i[9:2]`, clear `valid`, and go to FETCH0.
  - FETCH0: `mem_req_o=1`, `mem_addr_o=fill_tag`. On `mem_ack_i`: `hi <= mem_rdata_i`, go to FETCH1.
  - FETCH1: `mem_req_o=1`, `mem_addr_o=fill_tag+1` (mod 2^MEM_AW). On `mem_ack_i`: `lo <= mem_rdata_i`, `tag <= fill_tag`, `valid <= 1`, go to IDLE.
- Address and request are held stable until ack; at most one outstanding request.
- `iaddr_i` changing mid-fill is ignored. The fill completes for `fill_tag`, then IDLE re-evaluates the hit.
- Wrap-around: the packet at byte address 0x3FC returns {word 0xFF, word 0x00}.
- `mem_ack_i` in IDLE is ignored.
- Reset values: `f2_stall_o=1` (valid=0), `mem_req_o=0`, `mem_addr_o=0`, `idata_o=0`, state IDLE.
- Reset mid-fill: the FSM returns to IDLE, the request drops, and a late ack is discarded.

## Timing
- Miss in cycle N (IDLE): FETCH0 is active from N+1.
- With zero-wait ack: FETCH1 at N+2, hit at N+3, giving 3 stall cycles. Each memory wait cycle adds one stall cycle.
- Hit at the same address costs 0 cycles, so the stall stays low.
- `mem_req_o` and `mem_addr_o` are state-decoded, with no combinational path from `mem_ack_i`.

## Configuration
- `IMEM_NEXT_PACKET_PREFETCH_EN` defined: adds buffer B and states PRE0/PRE1.
  - After a demand fill, or on promotion, B fetches the packet at `tag+2` using the same two-word protocol.
  - A hit in B is also a hit (mux B onto `idata_o`). On the next clock, B is copied into A, B is invalidated, and prefetch of the following packet starts.
  - A demand miss (not in A or B) during PRE0/PRE1 lets any in-flight request finish at its ack, drops the prefetch with B invalid, then goes to FETCH0.
- Undefined: single buffer only; PRE states and buffer B are not synthesized.

## Structure
- Shared package `imem_pkg`:
  - state enum (IDLE, FETCH0, FETCH1, PRE0, PRE1)
  - `PKT_W=64`, `WORD_W=32`, default `MEM_AW`
- Sub-module `fetch_packet_buffer`: one tag/valid/64-bit entry with load ports and a hit comparator. Instanced once for A, and a second time for B under the macro.

## Test plan
- Reset, then `iaddr_i=0x010` with zero-wait memory (word4=0xAAAA0001, word5=0xBBBB0002) -> stall for 3 cycles, then `idata_o=0xAAAA0001BBBB0002`; `mem_addr_o` sequence is 4, 5.
- Same address held for 5 more cycles -> stall stays low and `mem_req_o` stays 0.
- `iaddr_i=0x3FC` -> `mem_addr_o` sequence is 0xFF, then 0x00; packet is {mem[255], mem[0]}.
- Ack delayed 4 cycles per word -> `mem_req_o` and `mem_addr_o` held steady throughout; stall lasts 11 cycles.
- `iaddr_i` changed from 0x020 to 0x040 during FETCH1 -> the 0x020 fill completes, then a new miss fetches words 16, 17.
- `reset_i` pulsed in FETCH1 with ack arriving the next cycle -> ack ignored, `valid=0`, `f2_stall_o=1`, `mem_req_o=0`.
- Under the macro, sequential fetch 0x000 then 0x008 -> the second access shows zero stall after prefetch, and `mem_addr_o` then shows 4, 5.

Source files
------------

// File: rtl/imem_fetch_responder_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch responder.
// Optional feature macro used by the slice: IMEM_NEXT_PACKET_PREFETCH_EN.
package imem_pkg;

  localparam int PKT_W          = 64;
  localparam int WORD_W         = 32;
  localparam int DEFAULT_MEM_AW = 8;

  // PRE0/PRE1 are only reachable when next-packet prefetch is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    PRE0   = 3'd3,
    PRE1   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Bus bundle for imem_fetch_responder: F2 fetch port, backing-memory port and
// a debug view of the fill FSM state.
//
// Memory handshake: the responder raises mem_req_o with mem_addr_o and holds
// both unchanged until a cycle in which mem_ack_i is high; that cycle
// transfers mem_rdata_i and retires the request. Only one request is ever
// outstanding, and mem_ack_i is ignored whenever mem_req_o is low.
interface imem_fetch_responder_if #(
  parameter int MEM_AW = imem_pkg::DEFAULT_MEM_AW
);
  import imem_pkg::*;

  logic [MEM_AW+1:0] iaddr_i;
  logic [PKT_W-1:0]  idata_o;
  logic              f2_stall_o;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [WORD_W-1:0] mem_rdata_i;
  fetch_state_e      dbg_state;

  modport slave (
    input  iaddr_i, mem_ack_i, mem_rdata_i,
    output idata_o, f2_stall_o, mem_req_o, mem_addr_o, dbg_state
  );

  modport master (
    output iaddr_i, mem_ack_i, mem_rdata_i,
    input  idata_o, f2_stall_o, mem_req_o, mem_addr_o, dbg_state
  );

endinterface

// File: rtl/imem_fetch_responder_buffer.sv
// fetch_packet_buffer: one valid/tag/64-bit packet entry with word-wise fill
// ports, a whole-entry copy port and a tag hit comparator.
module fetch_packet_buffer
  import imem_pkg::*;
#(
  parameter int AW = DEFAULT_MEM_AW
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic              copy_we_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [AW-1:0]     load_tag_i,
  input  logic [PKT_W-1:0]  copy_data_i,
  input  logic [AW-1:0]     lookup_tag_i,
  output logic              hit_o,
  output logic [PKT_W-1:0]  data_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;

  // Entry storage: the low word completes a fill and makes the entry valid.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_o  <= '0;
    end else if (copy_we_i) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag_i;
      data_o  <= copy_data_i;
    end else if (lo_we_i) begin
      valid_q             <= 1'b1;
      tag_q               <= load_tag_i;
      data_o[WORD_W-1:0]  <= word_i;
    end else begin
      if (hi_we_i) data_o[PKT_W-1:WORD_W] <= word_i;
      if (clear_i) valid_q <= 1'b0;
    end
  end

  // Hit compare against the requested packet's slot-0 word address.
  always_comb begin
    hit_o = valid_q && (tag_q == lookup_tag_i);
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: dual-word fetch packet responder backed by a 32-bit
// single-word instruction memory. Defining IMEM_NEXT_PACKET_PREFETCH_EN adds
// a second packet buffer that prefetches the next sequential packet.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int MEM_AW = DEFAULT_MEM_AW
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  imem_fetch_responder_if.slave bus
);

  fetch_state_e      state_q, state_d;
  logic [MEM_AW-1:0] fill_tag_q;
  logic              fill_tag_we;
  logic [MEM_AW-1:0] req_tag;
  logic              hit;

  logic              a_clear, a_hi_we, a_lo_we, a_copy_we, a_hit;
  logic [MEM_AW-1:0] a_load_tag;
  logic [PKT_W-1:0]  a_copy_data, a_data;

  // Byte-offset bits of the fetch address carry no information here.
  logic unused_iaddr_bits;
  assign unused_iaddr_bits = &{1'b0, bus.iaddr_i[1:0]};

  assign req_tag = bus.iaddr_i[MEM_AW+1:2];

  fetch_packet_buffer #(.AW(MEM_AW)) u_buf_a (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (a_clear),
    .hi_we_i      (a_hi_we),
    .lo_we_i      (a_lo_we),
    .copy_we_i    (a_copy_we),
    .word_i       (bus.mem_rdata_i),
    .load_tag_i   (a_load_tag),
    .copy_data_i  (a_copy_data),
    .lookup_tag_i (req_tag),
    .hit_o        (a_hit),
    .data_o       (a_data)
  );

`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
  logic              b_clear, b_hi_we, b_lo_we, b_hit;
  logic [PKT_W-1:0]  b_data;
  logic [MEM_AW-1:0] pre_tag_q, pre_tag_d;
  logic              pre_tag_we;

  fetch_packet_buffer #(.AW(MEM_AW)) u_buf_b (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (b_clear),
    .hi_we_i      (b_hi_we),
    .lo_we_i      (b_lo_we),
    .copy_we_i    (1'b0),
    .word_i       (bus.mem_rdata_i),
    .load_tag_i   (pre_tag_q),
    .copy_data_i  ('0),
    .lookup_tag_i (req_tag),
    .hit_o        (b_hit),
    .data_o       (b_data)
  );

  // Prefetch target register; B's tag always equals it once B is valid.
  always_ff @(posedge clock_i) begin
    if (reset_i)         pre_tag_q <= '0;
    else if (pre_tag_we) pre_tag_q <= pre_tag_d;
  end

  // A hit in either buffer releases the stall; A wins if both match.
  always_comb begin
    hit          = a_hit || b_hit;
    bus.idata_o  = (b_hit && !a_hit) ? b_data : a_data;
    a_load_tag   = a_copy_we ? pre_tag_q : fill_tag_q;
    a_copy_data  = b_data;
  end
`else
  // Single buffer: the stall and packet come straight from A.
  always_comb begin
    hit          = a_hit;
    bus.idata_o  = a_data;
    a_load_tag   = fill_tag_q;
    a_copy_data  = '0;
  end
`endif

  assign bus.f2_stall_o = !hit;
  assign bus.dbg_state  = state_q;

  // State and demand-fill address registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      fill_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_tag_we) fill_tag_q <= req_tag;
    end
  end

  // Next state and state-decoded memory request; ack never reaches req/addr.
  always_comb begin
    state_d        = state_q;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = '0;
    fill_tag_we    = 1'b0;
    a_clear        = 1'b0;
    a_hi_we        = 1'b0;
    a_lo_we        = 1'b0;
    a_copy_we      = 1'b0;
`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
    b_clear        = 1'b0;
    b_hi_we        = 1'b0;
    b_lo_we        = 1'b0;
    pre_tag_we     = 1'b0;
    pre_tag_d      = pre_tag_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
        if (b_hit && !a_hit) begin
          // Promote B and chase the packet after it.
          a_copy_we  = 1'b1;
          b_clear    = 1'b1;
          pre_tag_we = 1'b1;
          pre_tag_d  = pre_tag_q + MEM_AW'(2);
          state_d    = PRE0;
        end else
`endif
        if (!hit) begin
          fill_tag_we = 1'b1;
          a_clear     = 1'b1;
          state_d     = FETCH0;
        end
      end
      FETCH0: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = fill_tag_q;
        if (bus.mem_ack_i) begin
          a_hi_we = 1'b1;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = fill_tag_q + MEM_AW'(1);
        if (bus.mem_ack_i) begin
          a_lo_we = 1'b1;
`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
          b_clear    = 1'b1;
          pre_tag_we = 1'b1;
          pre_tag_d  = fill_tag_q + MEM_AW'(2);
          state_d    = PRE0;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
      PRE0, PRE1: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = (state_q == PRE0) ? pre_tag_q : pre_tag_q + MEM_AW'(1);
        if (bus.mem_ack_i) begin
          if (!a_hit) begin
            // Demand miss: drop the prefetch (B stays invalid) and refill A.
            b_clear     = 1'b1;
            fill_tag_we = 1'b1;
            a_clear     = 1'b1;
            state_d     = FETCH0;
          end else if (state_q == PRE0) begin
            b_hi_we = 1'b1;
            state_d = PRE1;
          end else begin
            b_lo_we = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a packet-level model.
module tb_imem_fetch_responder;
  import imem_pkg::*;

  localparam int MEM_AW = 8;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  imem_fetch_responder_if #(.MEM_AW(MEM_AW)) bus_if ();

  imem_fetch_responder #(.MEM_AW(MEM_AW)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus_if)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [7:0]  exp_q[$];
  int          mem_delay  = 0;
  bit          force_ack  = 1'b0;
  logic [31:0] force_data = '0;
  int          wcnt       = 0;
  bit          hold_valid = 1'b0;
  logic [7:0]  hold_addr  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Backing memory: acks after mem_delay wait cycles, checks address order
  // against exp_q and that the request address holds while it waits.
  always @(negedge clock_i) begin
    if (force_ack) begin
      bus_if.mem_ack_i   = 1'b1;
      bus_if.mem_rdata_i = force_data;
      wcnt       = 0;
      hold_valid = 1'b0;
    end else if (bus_if.mem_req_o) begin
      if (hold_valid) check("addr_hold", 64'(bus_if.mem_addr_o), 64'(hold_addr));
      else begin
        hold_addr  = bus_if.mem_addr_o;
        hold_valid = 1'b1;
      end
      if (wcnt >= mem_delay) begin
        bus_if.mem_ack_i   = 1'b1;
        bus_if.mem_rdata_i = mem[bus_if.mem_addr_o];
        wcnt       = 0;
        hold_valid = 1'b0;
        if (exp_q.size() == 0) check("unexpected_req", 64'(bus_if.mem_addr_o), 64'hFFFF);
        else check("mem_addr", 64'(bus_if.mem_addr_o), 64'(exp_q.pop_front()));
      end else begin
        bus_if.mem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      bus_if.mem_ack_i = 1'b0;
      wcnt       = 0;
      hold_valid = 1'b0;
    end
  end

  // Present an address (releasing reset) and count stall cycles until a hit.
  task automatic run_fetch(input logic [9:0] a, input int d,
                           output int stalls, output logic [63:0] data);
    @(posedge clock_i); #1;
    mem_delay      = d;
    reset_i        = 1'b0;
    bus_if.iaddr_i = a;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_i);
      if (!bus_if.f2_stall_o) break;
      stalls++;
    end
    data = bus_if.idata_o;
  endtask

  task automatic push_packet(input logic [7:0] w);
    logic [7:0] w1;
    w1 = w + 8'd1;
    exp_q.push_back(w);
    exp_q.push_back(w1);
  endtask

  typedef struct {
    logic [9:0]  addr;
    int          delay;
    bit          miss;
    int          exp_stalls;
    logic [63:0] exp_data;
  } vec_t;

  vec_t        vecs [6];
  int          stalls;
  logic [63:0] data;
  bit          res_valid;
  logic [7:0]  res_tag;
  logic [63:0] res_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
    mem[4] = 32'hAAAA_0001;
    mem[5] = 32'hBBBB_0002;
    bus_if.iaddr_i = '0;

    vecs[0] = '{10'h010, 0, 1'b1, 3,  64'hAAAA0001_BBBB0002};
    vecs[1] = '{10'h010, 0, 1'b0, 0,  64'hAAAA0001_BBBB0002};
    vecs[2] = '{10'h013, 0, 1'b0, 0,  64'hAAAA0001_BBBB0002};
    vecs[3] = '{10'h3FC, 0, 1'b1, 3,  64'hC0DE00FF_C0DE0000};
    vecs[4] = '{10'h100, 4, 1'b1, 11, 64'hC0DE0040_C0DE0041};
    vecs[5] = '{10'h104, 1, 1'b1, 5,  64'hC0DE0041_C0DE0042};

    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    check("rst_stall", 64'(bus_if.f2_stall_o), 64'd1);
    check("rst_req",   64'(bus_if.mem_req_o),  64'd0);
    check("rst_addr",  64'(bus_if.mem_addr_o), 64'd0);
    check("rst_idata", bus_if.idata_o,         64'd0);

`ifdef IMEM_NEXT_PACKET_PREFETCH_EN
    push_packet(8'd0);
    push_packet(8'd2);
    run_fetch(10'h000, 0, stalls, data);
    check("pf_first_stall", 64'(stalls), 64'd3);
    check("pf_first_data", data, 64'hC0DE0000_C0DE0001);
    repeat (4) @(posedge clock_i);
    push_packet(8'd4);
    run_fetch(10'h008, 0, stalls, data);
    check("pf_second_stall", 64'(stalls), 64'd0);
    check("pf_second_data", data, 64'hC0DE0002_C0DE0003);
    repeat (4) @(posedge clock_i);
`else
    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].miss) push_packet(vecs[v].addr[9:2]);
      run_fetch(vecs[v].addr, vecs[v].delay, stalls, data);
      check($sformatf("vec%0d_stall", v), 64'(stalls), 64'(vecs[v].exp_stalls));
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
    end

    // Resident packet held: no stall, no memory traffic.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      check("hold_stall", 64'(bus_if.f2_stall_o), 64'd0);
      check("hold_req",   64'(bus_if.mem_req_o),  64'd0);
    end

    // Stray ack while idle must not disturb the packet.
    @(posedge clock_i); #1;
    force_data = 32'hDEAD_BEEF;
    force_ack  = 1'b1;
    @(posedge clock_i); #1;
    force_ack  = 1'b0;
    @(negedge clock_i);
    check("idle_ack_data",  bus_if.idata_o, 64'hC0DE0041_C0DE0042);
    check("idle_ack_stall", 64'(bus_if.f2_stall_o), 64'd0);
    check("idle_ack_req",   64'(bus_if.mem_req_o),  64'd0);

    // Address changes during the second word: old fill completes, then refill.
    @(posedge clock_i); #1;
    mem_delay      = 0;
    bus_if.iaddr_i = 10'h020;
    push_packet(8'd8);
    push_packet(8'd16);
    @(posedge clock_i);
    @(posedge clock_i); #1;
    bus_if.iaddr_i = 10'h040;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_i);
      if (!bus_if.f2_stall_o) break;
      stalls++;
    end
    check("midfill_stall", 64'(stalls), 64'd4);
    check("midfill_data", bus_if.idata_o, 64'hC0DE0010_C0DE0011);
    check("midfill_q", 64'(exp_q.size()), 64'd0);

    // Reset during the second word, with a late ack right after it.
    @(posedge clock_i); #1;
    mem_delay      = 1;
    bus_if.iaddr_i = 10'h080;
    push_packet(8'd32);
    @(posedge clock_i);
    @(posedge clock_i);
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i    = 1'b0;
    force_data = 32'h5A5A_5A5A;
    force_ack  = 1'b1;
    exp_q.delete();
    push_packet(8'd32);
    @(negedge clock_i);
    check("rstfill_stall", 64'(bus_if.f2_stall_o), 64'd1);
    check("rstfill_req",   64'(bus_if.mem_req_o),  64'd0);
    stalls = 1;
    @(posedge clock_i); #1;
    force_ack = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_i);
      if (!bus_if.f2_stall_o) break;
      stalls++;
    end
    check("rstfill_total_stall", 64'(stalls), 64'd5);
    check("rstfill_data", bus_if.idata_o, 64'hC0DE0020_C0DE0021);

    // Randomized run against a resident-packet model.
    check("pre_rand_q", 64'(exp_q.size()), 64'd0);
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    @(posedge clock_i);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    res_valid = 1'b0;
    res_tag   = '0;
    res_data  = '0;
    for (int t = 0; t < 40; t++) begin
      logic [9:0]  a;
      logic [7:0]  w, w1;
      int          d, exp_st;
      logic [63:0] exp_data;
      if (res_valid && $urandom_range(0, 2) == 0) a = {res_tag, 2'($urandom_range(0, 3))};
      else a = 10'($urandom);
      d  = $urandom_range(0, 3);
      w  = a[9:2];
      w1 = w + 8'd1;
      if (res_valid && w == res_tag) begin
        exp_st   = 0;
        exp_data = res_data;
      end else begin
        exp_st   = 3 + 2 * d;
        exp_data = {mem[w], mem[w1]};
        push_packet(w);
        res_valid = 1'b1;
        res_tag   = w;
        res_data  = exp_data;
      end
      run_fetch(a, d, stalls, data);
      check($sformatf("rand%0d_stall", t), 64'(stalls), 64'(exp_st));
      check($sformatf("rand%0d_data", t), data, exp_data);
    end
`endif

    repeat (3) @(posedge clock_i);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
